mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit (HI/LO subsystem) that sits beside the ALU in the EX stage of the pipelined MIPS core.
- Accepts one multicycle MULT/MULTU/DIV/DIVU operation at a time and models its latency with a busy counter.
- Owns the HI and LO architectural registers and handles MTHI/MTLO writes.
- Drives Busy and a Stall term that the hazard unit uses to freeze MFHI/MFLO and any new MDU instruction.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  EX-stage MDU instruction valid this cycle
MDOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
B  input  32  rt operand (divisor / multiplier)
Busy  output  1  multicycle operation in flight
Stall  output  1  combinational: Busy | (Start & MDOp<=3)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- One clock; reset is asynchronous and active-high. The clock port is clk and the reset port is reset.
- While reset is high: HI=0, LO=0, Busy=0, internal counter=0, pending results=0.
- Reset asserted mid-operation aborts it: HI/LO are cleared and the pending result is discarded.
- States:
  - IDLE: counter==0, Busy=0.
  - RUN: counter!=0, Busy=1.
- Accepting an operation (IDLE, Start=1, MDOp in 0..3, rising edge):
  - Operands are latched and the result is computed into pending PH/PL.
  - Counter loads MULT_CYCLES for MDOp 0/1 or DIV_CYCLES for MDOp 2/3.
- Busy is high for exactly N cycles after the accepting edge.
- Each edge in RUN decrements the counter. On the edge where the counter goes 1->0:
  - HI<=PH and LO<=PL.
  - The new HI/LO values become visible in the same cycle that Busy falls.
- Start during RUN (any MDOp) is ignored and causes no state change. Upstream is stalled in that case.
- MTHI/MTLO:
  - In IDLE with Start=1, HI<=A (or LO<=A) at the next edge. Busy stays 0 and Stall stays 0.
  - During RUN they are ignored.
- MDOp 6-7 with Start: no effect.
- Arithmetic:
  - MULT: {PH,PL} = signed 64-bit product of A and B.
  - MULTU: {PH,PL} = unsigned 64-bit product.
  - DIV: PL = signed quotient truncated toward zero; PH = remainder with the sign of the dividend.
  - DIVU: PL = unsigned quotient; PH = unsigned remainder.
- DIV special case 0x80000000 / 0xFFFFFFFF: PL=0x80000000, PH=0. No trap.
- Divide by zero (B==0, DIV or DIVU): the operation still runs the full DIV_CYCLES with Busy high, but HI/LO are left unchanged at completion.
- HI/LO change only on reset, on completion edges, and on idle MTHI/MTLO edges.

Test Plan:
- Reset mid-MULT (assert at busy cycle 2) -> Busy=0, HI=0, LO=0 immediately (async). After release, MTLO A=5 -> LO=5 at the next edge.
- MULT A=0xFFFFFFFF, B=2 -> Busy high exactly 5 cycles, Stall=1 in the accept cycle, then HI=0xFFFFFFFF, LO=0xFFFFFFFE as Busy falls.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=2 -> LO=3, HI=1.
- MULT in flight, then Start with MTHI A=0x1234 and Start with DIVU during Busy -> both ignored. Final HI/LO equal the MULT result and Busy falls on cycle 5.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU B=0 with prior HI=0xAA, LO=0xBB -> 10 busy cycles, HI/LO stay 0xAA/0xBB.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide unit beside the ALU in the EX stage.
// Results are computed when an operation is accepted and committed to HI/LO after a fixed busy latency.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t             r_state;
    state_t             w_stateNext;
    logic [3:0]         r_count;
    logic [3:0]         w_countNext;
    logic [31:0]        r_ph;
    logic [31:0]        r_pl;
    logic               r_noWrite;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_idle;
    logic               w_isMdOp;
    logic               w_accept;
    logic               w_complete;
    logic               w_mtWrite;
    logic               w_divByZero;
    logic               w_divOverflow;
    logic [31:0]        w_phNext;
    logic [31:0]        w_plNext;

    logic signed [63:0] w_sProd;
    logic [63:0]        w_uProd;
    logic signed [31:0] w_sDivisor;
    logic [31:0]        w_uDivisor;
    logic signed [31:0] w_sQuot;
    logic signed [31:0] w_sRem;
    logic [31:0]        w_uQuot;
    logic [31:0]        w_uRem;

    assign w_idle        = (r_state == S_IDLE);
    assign w_isMdOp      = ~MDOp[2];
    assign w_accept      = w_idle & Start & w_isMdOp;
    assign w_complete    = (r_state == S_RUN) & (r_count == 4'd1);
    assign w_mtWrite     = w_idle & Start & ((MDOp == OP_MTHI) | (MDOp == OP_MTLO));
    assign w_divByZero   = (B == 32'd0);
    assign w_divOverflow = (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);

    assign w_sProd = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_uProd = {32'd0, A} * {32'd0, B};

    // Dividing by 1 instead of -1 gives the wrapped quotient 0x80000000 with remainder 0,
    // and a divisor of 1 keeps the divider defined when B is zero (result is discarded then).
    assign w_sDivisor = (w_divByZero | w_divOverflow) ? 32'sd1 : $signed(B);
    assign w_uDivisor = w_divByZero ? 32'd1 : B;
    assign w_sQuot    = $signed(A) / w_sDivisor;
    assign w_sRem     = $signed(A) % w_sDivisor;
    assign w_uQuot    = A / w_uDivisor;
    assign w_uRem     = A % w_uDivisor;

    always_comb begin
        w_phNext = 32'd0;
        w_plNext = 32'd0;
        case (MDOp)
            OP_MULT: begin
                w_phNext = w_sProd[63:32];
                w_plNext = w_sProd[31:0];
            end
            OP_MULTU: begin
                w_phNext = w_uProd[63:32];
                w_plNext = w_uProd[31:0];
            end
            OP_DIV: begin
                w_phNext = w_sRem;
                w_plNext = w_sQuot;
            end
            OP_DIVU: begin
                w_phNext = w_uRem;
                w_plNext = w_uQuot;
            end
            default: begin
                w_phNext = 32'd0;
                w_plNext = 32'd0;
            end
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_countNext = MDOp[1] ? DIV_LOAD : MULT_LOAD;
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                w_countNext = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_countNext = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph      <= 32'd0;
            r_pl      <= 32'd0;
            r_noWrite <= 1'b0;
        end else if (w_accept) begin
            r_ph      <= w_phNext;
            r_pl      <= w_plNext;
            r_noWrite <= MDOp[1] & w_divByZero;
        end
    end

    // HI/LO move only on completion of a non-faulting operation or on an idle MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_complete) begin
            if (!r_noWrite) begin
                r_hi <= r_ph;
                r_lo <= r_pl;
            end
        end else if (w_mtWrite) begin
            if (MDOp == OP_MTHI) begin
                r_hi <= A;
            end
            if (MDOp == OP_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign Busy  = (r_state == S_RUN);
    assign Stall = Busy | (Start & w_isMdOp);
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks;
    int          errors;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Stall(Stall),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = s;
        MDOp  = op;
        A     = a;
        B     = b;
    endtask

    // Reference model: architectural effect of one accepted instruction on HI/LO.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        logic [31:0]     ma, mb, mq, mr;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                expHi = sp[63:32];
                expLo = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                expHi = up[63:32];
                expLo = up[31:0];
            end
            3'd2: begin
                if (b != 0) begin
                    ma = a[31] ? (~a + 32'd1) : a;
                    mb = b[31] ? (~b + 32'd1) : b;
                    mq = ma / mb;
                    mr = ma % mb;
                    expLo = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
                    expHi = a[31] ? (~mr + 32'd1) : mr;
                end
            end
            3'd3: begin
                if (b != 0) begin
                    expLo = a / b;
                    expHi = a % b;
                end
            end
            3'd4: expHi = a;
            3'd5: expLo = a;
            default: ;
        endcase
    endtask

    // Issue a multicycle op at a negedge and follow it until Busy drops; optionally poke Start while busy.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        int          n;
        int          cnt;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        n     = (op < 3'd2) ? MULT_N : DIV_N;
        oldHi = expHi;
        oldLo = expLo;
        applyStimulus(1'b1, op, a, b);
        #1 checkOutput("stall_accept", {31'd0, Stall}, 32'd1);
        modelOp(op, a, b);
        @(negedge clk);
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 20) begin
            cnt++;
            if (cnt == n) begin
                checkOutput("hi_hold_last_busy", HI, oldHi);
                checkOutput("lo_hold_last_busy", LO, oldLo);
            end
            if (inject && cnt == 1) begin
                applyStimulus(1'b1, 3'd4, 32'h0000_1234, 32'd0);
                #1 checkOutput("stall_busy_mthi", {31'd0, Stall}, 32'd1);
            end else if (inject && cnt == 2) begin
                applyStimulus(1'b1, 3'd3, 32'd7, 32'd2);
                #1 checkOutput("stall_busy_divu", {31'd0, Stall}, 32'd1);
            end else begin
                applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
            end
            @(negedge clk);
        end
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
        checkOutput("busy_cycles", cnt, n);
        checkOutput("hi_result", HI, expHi);
        checkOutput("lo_result", LO, expLo);
    endtask

    // Single-cycle op (MTHI/MTLO/no-op) issued while idle.
    task automatic idleOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, op, a, b);
        #1 checkOutput("stall_idle_op", {31'd0, Stall}, 32'd0);
        modelOp(op, a, b);
        @(negedge clk);
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
        checkOutput("busy_idle_op", {31'd0, Busy}, 32'd0);
        checkOutput("hi_idle_op", HI, expHi);
        checkOutput("lo_idle_op", LO, expLo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;
        errors = 0;
        expHi  = 32'd0;
        expLo  = 32'd0;
        reset  = 1'b1;
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);

        @(negedge clk);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_stall", {31'd0, Stall}, 32'd0);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        reset = 1'b0;

        $display("[TB] reset abort of an in-flight MULT");
        idleOp(3'd4, 32'h0000_DEAD, 32'd0);
        idleOp(3'd5, 32'h0000_BEEF, 32'd0);
        applyStimulus(1'b1, 3'd0, 32'd3, 32'd4);
        @(negedge clk);
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
        checkOutput("abort_hi", HI, 32'd0);
        checkOutput("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expHi = 32'd0;
        expLo = 32'd0;
        idleOp(3'd5, 32'd5, 32'd0);
        checkOutput("mtlo_after_reset", LO, 32'd5);
        repeat (MULT_N + 2) @(negedge clk);
        checkOutput("aborted_hi_stays", HI, 32'd0);
        checkOutput("aborted_lo_stays", LO, 32'd5);

        $display("[TB] directed multiply/divide");
        runOp(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        checkOutput("mult_hi_const", HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo_const", LO, 32'hFFFF_FFFE);
        runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        checkOutput("multu_hi_const", HI, 32'h0000_0001);
        checkOutput("multu_lo_const", LO, 32'hFFFF_FFFE);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("div_hi_const", HI, 32'hFFFF_FFFF);
        checkOutput("div_lo_const", LO, 32'hFFFF_FFFD);
        runOp(3'd3, 32'd7, 32'd2, 1'b0);
        checkOutput("divu_hi_const", HI, 32'd1);
        checkOutput("divu_lo_const", LO, 32'd3);

        $display("[TB] Start ignored while busy");
        runOp(3'd0, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        checkOutput("ignored_hi_const", HI, 32'hFFFF_FFFF);
        checkOutput("ignored_lo_const", LO, 32'hFFFF_F448);

        $display("[TB] divide corner cases");
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("divovf_hi_const", HI, 32'd0);
        checkOutput("divovf_lo_const", LO, 32'h8000_0000);
        idleOp(3'd4, 32'h0000_00AA, 32'd0);
        idleOp(3'd5, 32'h0000_00BB, 32'd0);
        runOp(3'd3, 32'd123, 32'd0, 1'b0);
        checkOutput("divz_hi_const", HI, 32'h0000_00AA);
        checkOutput("divz_lo_const", LO, 32'h0000_00BB);
        runOp(3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        idleOp(3'd6, 32'h1111_1111, 32'd0);
        idleOp(3'd7, 32'h2222_2222, 32'd0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: b = $urandom;
            endcase
            if (op < 3'd4) begin
                runOp(op, a, b, bit'($urandom_range(0, 1)));
            end else begin
                idleOp(op, a, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
